// File: rtl/gba_gfx_pkg.sv
// Shared geometry defaults and buffer-index helpers for the graphics scan driver.
package gba_gfx_pkg;

  localparam int unsigned GBA_H_ACTIVE = 240;
  localparam int unsigned GBA_H_TOTAL  = 308;
  localparam int unsigned GBA_V_ACTIVE = 160;
  localparam int unsigned GBA_V_TOTAL  = 228;
  localparam int unsigned GBA_DOT_DIV  = 4;
  localparam int unsigned GBA_ROW_W    = 8;
  localparam int unsigned GBA_ADDR_W   = 17;
  localparam int unsigned GBA_NUM_BUFS = 2;

  // Wide enough for the largest supported rotation (3 buffers).
  localparam int unsigned BUF_IDX_W = 2;
  typedef logic [BUF_IDX_W-1:0] buf_idx_t;

  function automatic buf_idx_t next_buf(input buf_idx_t cur, input int unsigned num_bufs);
    if ((32'(cur) + 32'd1) >= num_bufs) return '0;
    return cur + buf_idx_t'(1);
  endfunction

endpackage

// File: rtl/gfx_scan_driver_if.sv
// Scan-driver bus: pipeline/display controls in, timing, address and buffer indices out.
interface gfx_scan_driver_if
  import gba_gfx_pkg::*;
#(
  parameter int unsigned H_TOTAL  = GBA_H_TOTAL,
  parameter int unsigned ROW_W    = GBA_ROW_W,
  parameter int unsigned ADDR_W   = GBA_ADDR_W,
  parameter int unsigned NUM_BUFS = GBA_NUM_BUFS
);
  localparam int unsigned HCNT_W = $clog2(H_TOTAL);
  localparam int unsigned BUF_W  = $clog2(NUM_BUFS);

  logic              en;
  logic [ROW_W-1:0]  vcount_cmp;
  logic              rd_frame_done;
  logic              wen;
  logic [ADDR_W-1:0] graphics_addr;
  logic [ROW_W-1:0]  vcount;
  logic [HCNT_W-1:0] hcount;
  logic              hblank;
  logic              vblank;
  logic              vcount_match;
  logic [BUF_W-1:0]  write_buf;
  logic [BUF_W-1:0]  read_buf;
  logic              swap;
  logic              frame_drop;

  modport master (
    input  en, vcount_cmp, rd_frame_done,
    output wen, graphics_addr, vcount, hcount, hblank, vblank, vcount_match,
           write_buf, read_buf, swap, frame_drop
  );

  modport slave (
    output en, vcount_cmp, rd_frame_done,
    input  wen, graphics_addr, vcount, hcount, hblank, vblank, vcount_match,
           write_buf, read_buf, swap, frame_drop
  );
endinterface

// File: rtl/scan_counter.sv
// Wrapping up-counter 0..MAX with synchronous clear; last flags the terminal count.
module scan_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MAX   = 255
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             en,
  input  logic             clear,
  output logic             last,
  output logic [WIDTH-1:0] q
);

  assign last = (q == WIDTH'(MAX));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)     q <= '0;
    else if (clear) q <= '0;
    else if (en)    q <= last ? '0 : q + WIDTH'(1);
  end

endmodule

// File: rtl/gfx_scan_driver.sv
// Scan timing and N-way frame-buffer rotation for the graphics pipeline.
module gfx_scan_driver
  import gba_gfx_pkg::*;
#(
  parameter int unsigned H_ACTIVE = GBA_H_ACTIVE,
  parameter int unsigned H_TOTAL  = GBA_H_TOTAL,
  parameter int unsigned V_ACTIVE = GBA_V_ACTIVE,
  parameter int unsigned V_TOTAL  = GBA_V_TOTAL,
  parameter int unsigned DOT_DIV  = GBA_DOT_DIV,
  parameter int unsigned ROW_W    = GBA_ROW_W,
  parameter int unsigned ADDR_W   = GBA_ADDR_W,
  parameter int unsigned NUM_BUFS = GBA_NUM_BUFS
) (
  input  logic              clk,
  input  logic              rst_b,
  gfx_scan_driver_if.master bus
);

  localparam int unsigned HCNT_W = $clog2(H_TOTAL);
  localparam int unsigned DOT_W  = (DOT_DIV > 1) ? $clog2(DOT_DIV) : 1;
  localparam int unsigned BUF_W  = $clog2(NUM_BUFS);
  localparam int unsigned PIXELS = H_ACTIVE * V_ACTIVE;

  logic [DOT_W-1:0]  dot;
  logic [HCNT_W-1:0] hcount;
  logic [ROW_W-1:0]  vcount;
  logic [ADDR_W-1:0] addr;
  logic              dot_last, h_last, v_last, addr_last;
  logic              step, wen, hblank, vblank, frame_end;
  logic              rd_ready, swap, frame_drop;
  buf_idx_t          write_idx, read_idx;

  scan_counter #(.WIDTH(DOT_W), .MAX(DOT_DIV - 1)) u_dot (
    .clk(clk), .rst_b(rst_b), .en(bus.en), .clear(1'b0), .last(dot_last), .q(dot)
  );

  scan_counter #(.WIDTH(HCNT_W), .MAX(H_TOTAL - 1)) u_hcount (
    .clk(clk), .rst_b(rst_b), .en(step), .clear(1'b0), .last(h_last), .q(hcount)
  );

  scan_counter #(.WIDTH(ROW_W), .MAX(V_TOTAL - 1)) u_vcount (
    .clk(clk), .rst_b(rst_b), .en(step & h_last), .clear(1'b0), .last(v_last), .q(vcount)
  );

  // Address walks linearly with each strobe, so row*H_ACTIVE+col needs no multiplier.
  scan_counter #(.WIDTH(ADDR_W), .MAX(PIXELS - 1)) u_addr (
    .clk(clk), .rst_b(rst_b), .en(wen), .clear(frame_end), .last(addr_last), .q(addr)
  );

  assign step      = bus.en & dot_last;
  assign hblank    = (hcount >= HCNT_W'(H_ACTIVE));
  assign vblank    = (vcount >= ROW_W'(V_ACTIVE));
  assign wen       = step & ~hblank & ~vblank;
  assign frame_end = step & h_last & v_last;

  // A read completion landing on the frame-end cycle still counts as ready.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      write_idx  <= '0;
      read_idx   <= buf_idx_t'(NUM_BUFS - 1);
      rd_ready   <= 1'b1;
      swap       <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      swap       <= 1'b0;
      frame_drop <= 1'b0;
      if (frame_end) begin
        if (rd_ready | bus.rd_frame_done) begin
          read_idx  <= write_idx;
          write_idx <= next_buf(write_idx, NUM_BUFS);
          rd_ready  <= 1'b0;
          swap      <= 1'b1;
        end else begin
          frame_drop <= 1'b1;
        end
      end else if (bus.rd_frame_done) begin
        rd_ready <= 1'b1;
      end
    end
  end

  assign bus.wen           = wen;
  assign bus.graphics_addr = addr;
  assign bus.hcount        = hcount;
  assign bus.vcount        = vcount;
  assign bus.hblank        = hblank;
  assign bus.vblank        = vblank;
  assign bus.vcount_match  = (vcount == bus.vcount_cmp);
  assign bus.write_buf     = BUF_W'(write_idx);
  assign bus.read_buf      = BUF_W'(read_idx);
  assign bus.swap          = swap;
  assign bus.frame_drop    = frame_drop;

  logic unused_ok;
  assign unused_ok = &{1'b0, dot, addr_last};

endmodule

// File: tb/tb_gfx_scan_driver.sv
// Scoreboard bench for gfx_scan_driver: a position-based frame model predicts every cycle.
module tb_gfx_scan_driver;

  localparam int unsigned HA = 4;
  localparam int unsigned HT = 6;
  localparam int unsigned VA = 3;
  localparam int unsigned VT = 5;
  localparam int unsigned DD = 2;
  localparam int unsigned NB = 3;
  localparam int unsigned RW = 3;
  localparam int unsigned AW = 4;
  localparam int FRAME_DOTS = HT * VT;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  gfx_scan_driver_if #(.H_TOTAL(HT), .ROW_W(RW), .ADDR_W(AW), .NUM_BUFS(NB)) bus ();

  gfx_scan_driver #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
    .DOT_DIV(DD), .ROW_W(RW), .ADDR_W(AW), .NUM_BUFS(NB)
  ) dut (
    .clk(clk), .rst_b(rst_b), .bus(bus)
  );

  typedef struct {
    bit wen;
    int addr, h, v;
    bit hb, vb, m, sw, dr;
    int wb, rb;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  // Model: linear dot position within the frame plus the divider phase.
  int m_phase, m_pos, m_wb, m_rb;
  bit m_ready, m_swap, m_drop;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_pos = 0; m_wb = 0; m_rb = NB - 1;
    m_ready = 1'b1; m_swap = 1'b0; m_drop = 1'b0;
  endtask

  task automatic model_cycle();
    exp_t e;
    int h, v;
    bit step;
    h = m_pos % HT;
    v = m_pos / HT;
    step = rst_b && bus.en && (m_phase == DD - 1);
    e.wen = step && (h < HA) && (v < VA);
    e.addr = v * HA + h;
    e.h = h; e.v = v;
    e.hb = (h >= HA); e.vb = (v >= VA);
    e.m = (v == int'(bus.vcount_cmp));
    e.sw = m_swap; e.dr = m_drop;
    e.wb = m_wb; e.rb = m_rb;
    sb_q.push_back(e);
    if (!rst_b) return;
    m_swap = 1'b0;
    m_drop = 1'b0;
    if (step && m_pos == FRAME_DOTS - 1) begin
      if (m_ready || bus.rd_frame_done) begin
        m_rb = m_wb;
        m_wb = (m_wb + 1) % NB;
        m_ready = 1'b0;
        m_swap = 1'b1;
      end else begin
        m_drop = 1'b1;
      end
    end else if (bus.rd_frame_done) begin
      m_ready = 1'b1;
    end
    if (bus.en) begin
      if (step) m_pos = (m_pos + 1) % FRAME_DOTS;
      m_phase = (m_phase + 1) % DD;
    end
  endtask

  task automatic cycle(input bit en, input bit done, input int cmp, input bit rstv);
    @(posedge clk);
    #1;
    bus.en = en;
    bus.rd_frame_done = done;
    bus.vcount_cmp = RW'(cmp);
    rst_b = rstv;
    if (!rstv) model_reset();
    #1;
    model_cycle();
  endtask

  function automatic bit at_frame_end();
    return (m_phase == DD - 1) && (m_pos == FRAME_DOTS - 1);
  endfunction

  // Monitor: compare every presented cycle against the queued prediction.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      chk("wen", int'(bus.wen), int'(mon_e.wen));
      if (mon_e.wen) chk("graphics_addr", int'(bus.graphics_addr), mon_e.addr);
      chk("hcount", int'(bus.hcount), mon_e.h);
      chk("vcount", int'(bus.vcount), mon_e.v);
      chk("hblank", int'(bus.hblank), int'(mon_e.hb));
      chk("vblank", int'(bus.vblank), int'(mon_e.vb));
      chk("vcount_match", int'(bus.vcount_match), int'(mon_e.m));
      chk("swap", int'(bus.swap), int'(mon_e.sw));
      chk("frame_drop", int'(bus.frame_drop), int'(mon_e.dr));
      chk("write_buf", int'(bus.write_buf), mon_e.wb);
      chk("read_buf", int'(bus.read_buf), mon_e.rb);
      chk("bufs_distinct", int'(bus.write_buf != bus.read_buf), 1);
    end
  end

  initial begin
    bit fe;
    int cmp;
    bus.en = 1'b0;
    bus.rd_frame_done = 1'b0;
    bus.vcount_cmp = RW'(3);
    model_reset();

    // Reset state, then two frames with no reader completions: swap then drop.
    repeat (2) cycle(1'b0, 1'b0, 3, 1'b0);
    for (int i = 0; i < 2 * FRAME_DOTS * DD; i++) cycle(1'b1, 1'b0, 3, 1'b1);

    // Reader completion exactly on the frame-end cycle.
    for (int i = 0; i < 2 * FRAME_DOTS * DD; i++) begin
      fe = at_frame_end();
      cycle(1'b1, fe, 3, 1'b1);
      if (fe) break;
    end
    // Mid-frame completion followed by a full frame: exactly one swap.
    for (int i = 0; i < FRAME_DOTS * DD; i++) cycle(1'b1, (i == 20), 3, 1'b1);

    // Freeze mid-line at hcount 2 for 7 cycles.
    for (int i = 0; i < 2 * FRAME_DOTS * DD; i++) begin
      if ((m_pos % HT == 2) && (m_pos / HT < VA) && m_phase == 0) break;
      cycle(1'b1, 1'b0, 3, 1'b1);
    end
    repeat (7) cycle(1'b0, 1'b0, 3, 1'b1);
    for (int i = 0; i < FRAME_DOTS * DD; i++) cycle(1'b1, 1'b0, 3, 1'b1);

    // Three-buffer rotation with a completion every frame.
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < FRAME_DOTS * DD; i++) cycle(1'b1, (i == 30), 3, 1'b1);

    // Mid-frame reset at cycle 37, then timing restarts from zero.
    cycle(1'b1, 1'b0, 3, 1'b0);
    for (int i = 0; i < 37; i++) cycle(1'b1, (i == 10), 3, 1'b1);
    cycle(1'b1, 1'b0, 3, 1'b0);
    for (int i = 0; i < 70; i++) cycle(1'b1, 1'b0, 3, 1'b1);

    // Randomised traffic.
    cmp = 3;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 49) == 0) cmp = int'($urandom_range(0, 7));
      cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0), cmp,
            ($urandom_range(0, 599) != 0));
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
